// File: rtl/id_ex_pipereg.sv
// id_ex_pipereg: ID->EX pipeline register with load-use bubble insertion, flush and bubble counter
module id_ex_pipereg #(
  parameter int XLEN = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int CTRL_W = 64,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [XLEN-1:0]          id_pc,
  input  logic [XLEN-1:0]          id_inst,
  input  logic [CTRL_W-1:0]        id_ctrl,
  input  logic [XLEN-1:0]          id_rs1,
  input  logic [XLEN-1:0]          id_rs2,
  input  logic [XLEN-1:0]          id_imm,
  input  logic [RF_ADDR_WIDTH-1:0] id_rf_raddr1,
  input  logic [RF_ADDR_WIDTH-1:0] id_rf_raddr2,
  input  logic                     id_uses_rs1,
  input  logic                     id_uses_rs2,
  input  logic                     id_req_rf,
  input  logic [RF_ADDR_WIDTH-1:0] id_rf_waddr,
  input  logic                     id_is_load,
  input  logic                     id_exp_flag,
  input  logic                     ex_ready_go,
  input  logic                     mem_allowin,
  input  logic                     flush,
  output logic                     ld_risk,
  output logic                     id_allowin,
  output logic                     ex_valid,
  output logic [XLEN-1:0]          ex_pc,
  output logic [XLEN-1:0]          ex_inst,
  output logic [XLEN-1:0]          ex_rs1,
  output logic [XLEN-1:0]          ex_rs2,
  output logic [XLEN-1:0]          ex_imm,
  output logic [CTRL_W-1:0]        ex_ctrl,
  output logic                     ex_req_rf,
  output logic [RF_ADDR_WIDTH-1:0] ex_rf_waddr,
  output logic                     ex_is_load,
  output logic                     ex_exp_flag,
  output logic [31:0]              bubble_cnt
);
  logic                     ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]          ex_pc_q, ex_pc_d, ex_inst_q, ex_inst_d;
  logic [XLEN-1:0]          ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_imm_q, ex_imm_d;
  logic [CTRL_W-1:0]        ex_ctrl_q, ex_ctrl_d;
  logic                     ex_req_rf_q, ex_req_rf_d, ex_is_load_q, ex_is_load_d;
  logic                     ex_exp_flag_q, ex_exp_flag_d;
  logic [RF_ADDR_WIDTH-1:0] ex_rf_waddr_q, ex_rf_waddr_d;
  logic [31:0]              bubble_cnt_q, bubble_cnt_d;
  logic                     ex_allowin;
  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_inst     = ex_inst_q;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign ex_imm      = ex_imm_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_rf_waddr = ex_rf_waddr_q;
  assign ex_req_rf   = ex_req_rf_q & ex_valid_q;
  assign ex_is_load  = ex_is_load_q & ex_valid_q;
  assign ex_exp_flag = ex_exp_flag_q & ex_valid_q;
  assign bubble_cnt  = bubble_cnt_q;
  assign ld_risk = ex_is_load & ex_req_rf & (ex_rf_waddr_q != '0) & id_valid &
                   ((id_uses_rs1 & (id_rf_raddr1 == ex_rf_waddr_q)) |
                    (id_uses_rs2 & (id_rf_raddr2 == ex_rf_waddr_q)));
  assign ex_allowin = ~ex_valid_q | (ex_ready_go & mem_allowin);
  assign id_allowin = ex_allowin & ~ld_risk & ~flush;
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_inst_d     = ex_inst_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_imm_d      = ex_imm_q;
    ex_ctrl_d     = ex_ctrl_q;
    ex_req_rf_d   = ex_req_rf_q;
    ex_rf_waddr_d = ex_rf_waddr_q;
    ex_is_load_d  = ex_is_load_q;
    ex_exp_flag_d = ex_exp_flag_q;
    bubble_cnt_d  = bubble_cnt_q;
    if (flush || (ex_allowin && (ld_risk || !id_valid))) begin
      ex_valid_d = 1'b0;
      ex_inst_d  = NOP_INST;
      bubble_cnt_d = bubble_cnt_q + {31'd0, ~flush & ld_risk};
    end else if (ex_allowin) begin
      ex_valid_d    = 1'b1;
      ex_pc_d       = id_pc;
      ex_inst_d     = id_inst;
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
      ex_imm_d      = id_imm;
      ex_ctrl_d     = id_ctrl;
      ex_req_rf_d   = id_req_rf;
      ex_rf_waddr_d = id_rf_waddr;
      ex_is_load_d  = id_is_load;
      ex_exp_flag_d = id_exp_flag;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_inst_q     <= NOP_INST;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_imm_q      <= '0;
      ex_ctrl_q     <= '0;
      ex_req_rf_q   <= 1'b0;
      ex_rf_waddr_q <= '0;
      ex_is_load_q  <= 1'b0;
      ex_exp_flag_q <= 1'b0;
      bubble_cnt_q  <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_inst_q     <= ex_inst_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_imm_q      <= ex_imm_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_req_rf_q   <= ex_req_rf_d;
      ex_rf_waddr_q <= ex_rf_waddr_d;
      ex_is_load_q  <= ex_is_load_d;
      ex_exp_flag_q <= ex_exp_flag_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end
endmodule

// File: tb/tb_id_ex_pipereg.sv
// tb_id_ex_pipereg: directed hazard/stall/flush/wrap scenarios plus random traffic against a field-level model
module tb_id_ex_pipereg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst;
  logic id_valid, id_uses_rs1, id_uses_rs2, id_req_rf, id_is_load, id_exp_flag;
  logic ex_ready_go, mem_allowin, flush;
  logic [31:0] id_pc, id_inst, id_rs1, id_rs2, id_imm;
  logic [63:0] id_ctrl;
  logic [4:0] id_rf_raddr1, id_rf_raddr2, id_rf_waddr;
  logic ld_risk, id_allowin, ex_valid, ex_req_rf, ex_is_load, ex_exp_flag;
  logic [31:0] ex_pc, ex_inst, ex_rs1, ex_rs2, ex_imm, bubble_cnt;
  logic [63:0] ex_ctrl;
  logic [4:0] ex_rf_waddr;
  id_ex_pipereg dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm),
    .id_rf_raddr1(id_rf_raddr1), .id_rf_raddr2(id_rf_raddr2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .id_req_rf(id_req_rf), .id_rf_waddr(id_rf_waddr),
    .id_is_load(id_is_load), .id_exp_flag(id_exp_flag), .ex_ready_go(ex_ready_go),
    .mem_allowin(mem_allowin), .flush(flush), .ld_risk(ld_risk), .id_allowin(id_allowin),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_req_rf(ex_req_rf), .ex_rf_waddr(ex_rf_waddr),
    .ex_is_load(ex_is_load), .ex_exp_flag(ex_exp_flag), .bubble_cnt(bubble_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic v, req, ld, exp;
    logic [31:0] pc, inst, rs1, rs2, imm;
    logic [63:0] ctrl;
    logic [4:0] wa;
  } ex_t;
  ex_t m;
  logic [31:0] m_cnt;
  int vecs = 0, errs = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic hazard();
    return m.v && m.ld && m.req && m.wa != 0 && id_valid &&
           ((id_uses_rs1 && id_rf_raddr1 == m.wa) || (id_uses_rs2 && id_rf_raddr2 == m.wa));
  endfunction
  function automatic logic can_take();
    return !m.v || (ex_ready_go && mem_allowin);
  endfunction
  task automatic model_reset();
    m.v = 0; m.req = 0; m.ld = 0; m.exp = 0; m.pc = 0; m.inst = NOP;
    m.rs1 = 0; m.rs2 = 0; m.imm = 0; m.ctrl = 0; m.wa = 0; m_cnt = 0;
  endtask
  task automatic check_regs();
    check("ex_valid", ex_valid, m.v);
    check("ex_pc", ex_pc, m.pc);
    check("ex_inst", ex_inst, m.inst);
    check("ex_ctrl", ex_ctrl, m.ctrl);
    check("ex_rs1", ex_rs1, m.rs1);
    check("ex_rs2", ex_rs2, m.rs2);
    check("ex_imm", ex_imm, m.imm);
    check("ex_req_rf", ex_req_rf, m.req && m.v);
    check("ex_rf_waddr", ex_rf_waddr, m.wa);
    check("ex_is_load", ex_is_load, m.ld && m.v);
    check("ex_exp_flag", ex_exp_flag, m.exp && m.v);
    check("bubble_cnt", bubble_cnt, m_cnt);
  endtask
  task automatic cycle();
    logic hz, tk;
    #1;
    hz = hazard();
    tk = can_take();
    if (!rst) begin
      check("ld_risk", ld_risk, hz);
      check("id_allowin", id_allowin, tk && !hz && !flush);
    end
    @(posedge clk);
    if (rst) model_reset();
    else if (flush) begin m.v = 0; m.inst = NOP; end
    else if (tk && hz) begin m.v = 0; m.inst = NOP; m_cnt = m_cnt + 1; end
    else if (tk && id_valid) begin
      m.v = 1; m.pc = id_pc; m.inst = id_inst; m.ctrl = id_ctrl; m.rs1 = id_rs1;
      m.rs2 = id_rs2; m.imm = id_imm; m.req = id_req_rf; m.wa = id_rf_waddr;
      m.ld = id_is_load; m.exp = id_exp_flag;
    end else if (tk) begin m.v = 0; m.inst = NOP; end
    #1 check_regs();
  endtask
  task automatic set_inst(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] a1,
                          input logic [4:0] a2, input logic u1, input logic u2, input logic ld);
    id_valid = 1; id_pc = pc; id_inst = {$urandom} | 32'h3; id_ctrl = {$urandom, $urandom};
    id_rs1 = $urandom; id_rs2 = $urandom; id_imm = $urandom;
    id_rf_waddr = rd; id_rf_raddr1 = a1; id_rf_raddr2 = a2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_req_rf = 1; id_is_load = ld; id_exp_flag = 0;
  endtask
  task automatic do_reset();
    rst = 1; flush = 0; ex_ready_go = 1; mem_allowin = 1; id_valid = 0;
    cycle();
    cycle();
    rst = 0;
  endtask
  initial begin
    id_pc = 0; id_inst = 0; id_ctrl = 0; id_rs1 = 0; id_rs2 = 0; id_imm = 0;
    id_rf_raddr1 = 0; id_rf_raddr2 = 0; id_rf_waddr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_req_rf = 0; id_is_load = 0; id_exp_flag = 0;
    model_reset();
    do_reset();
    check("rst_valid", ex_valid, 0);
    check("rst_inst", ex_inst, NOP);
    check("rst_cnt", bubble_cnt, 0);
    #1 check("rst_allowin", id_allowin, 1);
    set_inst(32'h100, 5, 1, 0, 1, 0, 1);
    cycle();
    set_inst(32'h104, 6, 5, 2, 1, 1, 0);
    #1 check("t2_risk", ld_risk, 1);
    cycle();
    check("t2_bubble", ex_valid, 0);
    cycle();
    check("t2_add_pc", ex_pc, 32'h104);
    check("t2_cnt", bubble_cnt, 1);
    do_reset();
    set_inst(32'h200, 0, 1, 0, 1, 0, 1);
    cycle();
    set_inst(32'h204, 6, 0, 2, 1, 1, 0);
    #1 check("t3_risk", ld_risk, 0);
    cycle();
    check("t3_pc", ex_pc, 32'h204);
    check("t3_cnt", bubble_cnt, 0);
    do_reset();
    set_inst(32'h300, 7, 1, 2, 1, 1, 0);
    cycle();
    set_inst(32'h304, 8, 3, 4, 1, 1, 0);
    ex_ready_go = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t4_hold_pc", ex_pc, 32'h300);
      check("t4_allowin", id_allowin, 0);
    end
    ex_ready_go = 1;
    cycle();
    check("t4_release_pc", ex_pc, 32'h304);
    do_reset();
    set_inst(32'h400, 5, 1, 0, 1, 0, 1);
    cycle();
    set_inst(32'h404, 6, 5, 2, 1, 1, 0);
    flush = 1;
    #1 check("t5_risk", ld_risk, 1);
    check("t5_allowin", id_allowin, 0);
    cycle();
    flush = 0;
    check("t5_valid", ex_valid, 0);
    check("t5_cnt", bubble_cnt, 0);
    do_reset();
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.bubble_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    #1 check("t6_pre", bubble_cnt, 32'hFFFF_FFFF);
    set_inst(32'h500, 5, 1, 0, 1, 0, 1);
    cycle();
    set_inst(32'h504, 6, 0, 5, 0, 1, 0);
    cycle();
    check("t6_wrap", bubble_cnt, 0);
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      set_inst($urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0));
      id_valid = 1'($urandom_range(0, 4) != 0);
      id_req_rf = 1'($urandom_range(0, 4) != 0);
      id_exp_flag = 1'($urandom_range(0, 7) == 0);
      ex_ready_go = 1'($urandom_range(0, 3) != 0);
      mem_allowin = 1'($urandom_range(0, 3) != 0);
      flush = 1'($urandom_range(0, 9) == 0);
      rst = 1'($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
